// File: rtl/ioctl_router_pkg.sv
// rtl/ioctl_router_pkg.sv - shared types and constants for the ioctl ROM router
//
// Purpose : FSM state encoding, hps_io download index values and the write
//           FIFO entry layout shared by ioctl_rom_router and ioctl_wr_fifo.
// Ports   : none (package).
package ioctl_router_pkg;

    // Widest ioctl address the FIFO entry can carry; the router zero-extends
    // its ADDR_W-bit address into this field.
    localparam int unsigned ADDR_MAX_W = 32;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_DIP = 8'd254;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } router_state_e;

    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic [7:0]            data;
        logic [2:0]            region;
    } fifo_entry_t;

    localparam int unsigned FIFO_ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/ioctl_wr_fifo.sv
// rtl/ioctl_wr_fifo.sv - synchronous write-buffer FIFO for routed ROM bytes
//
// Purpose : single-clock FIFO; push is ignored when full, pop when empty.
//           Reset flushes the pointers, so stored data needs no reset.
// Ports   : clk_i     clock
//           reset_i   synchronous active-high flush
//           push_i    write data_i this cycle
//           data_i    entry to write
//           pop_i     discard the head entry this cycle
//           data_o    head entry (valid while !empty_o)
//           count_o   number of stored entries
//           full_o    count_o == DEPTH
//           empty_o   count_o == 0
module ioctl_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the count unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ioctl_rom_router.sv
// rtl/ioctl_rom_router.sv - routes hps_io download bytes to DIP bank and ROM regions
//
// Purpose : captures DIP bytes (index 254) into dip_sw, routes ROM bytes
//           (index 0) through a write FIFO to a req/ack memory port tagged with
//           their region, back-pressures hps_io and holds the core in reset
//           until the load has fully drained.
// Macro   : IOCTL_ROUTER_CHECKSUM_EN adds rom_sum, the mod-2^16 sum of all
//           bytes acked by memory during a load.
// Ports   : clk_sys, reset           clock, synchronous active-high reset
//           ioctl_download/wr/index/addr/dout   hps_io download stream
//           ioctl_wait               back-pressure to hps_io
//           mem_req/addr/data/region memory write request, held until mem_ack
//           mem_ack                  memory accepted the current write
//           dip_sw                   DIP bytes, byte k at [8k+7:8k]
//           core_reset               high while loading/draining
//           load_done                one-cycle pulse when a load has drained
//           addr_err                 sticky: unmapped ROM byte or FIFO overflow
//           rom_sum                  (macro only) checksum of acked bytes
module ioctl_rom_router
    import ioctl_router_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned ADDR_W      = 25,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END =
        {25'h80000, 25'h34000, 25'h14000, 25'h0C000},
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DIP_BYTES   = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [ADDR_W-1:0]      ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic                   ioctl_wait,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [7:0]             mem_data,
    output logic [2:0]             mem_region,
    input  logic                   mem_ack,
    output logic [8*DIP_BYTES-1:0] dip_sw,
    output logic                   core_reset,
    output logic                   load_done,
    output logic                   addr_err
`ifdef IOCTL_ROUTER_CHECKSUM_EN
    ,
    output logic [15:0]            rom_sum
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    router_state_e          state_q, state_d;
    logic                   wait_q, wait_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [7:0]             mem_data_q, mem_data_d;
    logic [2:0]             mem_region_q, mem_region_d;
    logic [8*DIP_BYTES-1:0] dip_q, dip_d;
    logic                   core_reset_q, core_reset_d;
    logic                   load_done_q, load_done_d;
    logic                   addr_err_q, addr_err_d;

    logic                   rom_strobe;
    logic                   rom_hit;
    logic [2:0]             rom_region;
    logic                   push_req, push_ok, pop_ok;
    fifo_entry_t            push_entry, head;
    logic [FIFO_ENTRY_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]       fifo_count, count_next;
    logic                   fifo_full, fifo_empty;

    // ------------------------------------------------------------------
    // ROM byte classification: lowest region whose end is above the address.
    // Iterating downwards lets the lowest matching region win.
    // ------------------------------------------------------------------
    assign rom_strobe = ioctl_wr && ioctl_download && (ioctl_index == IDX_ROM);

    always_comb begin
        rom_hit    = 1'b0;
        rom_region = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (ioctl_addr < REGION_END[r*ADDR_W +: ADDR_W]) begin
                rom_hit    = 1'b1;
                rom_region = 3'(r);
            end
        end
    end

    always_comb begin
        push_entry        = '0;
        push_entry.addr   = ADDR_MAX_W'(ioctl_addr);
        push_entry.data   = ioctl_dout;
        push_entry.region = rom_region;
    end

    assign push_req = rom_strobe && rom_hit;
    assign push_ok  = push_req && !fifo_full;
    // The presented entry stays in the FIFO until memory accepts it.
    assign pop_ok   = mem_req_q && mem_ack;

    ioctl_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_sys),
        .reset_i (reset),
        .push_i  (push_req),
        .data_i  (push_entry),
        .pop_i   (pop_ok),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head = fifo_rdata;

    generate
        if (ADDR_W < ADDR_MAX_W) begin : g_addr_pad
            logic unused_addr_hi;
            assign unused_addr_hi = |head.addr[ADDR_MAX_W-1:ADDR_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Back-pressure: registered from the next occupancy so it is asserted in
    // the cycle the FIFO reaches DEPTH-1; the last slot absorbs the strobe
    // hps_io may already have in flight.
    // ------------------------------------------------------------------
    always_comb begin
        count_next = fifo_count;
        if (push_ok && !pop_ok) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = fifo_count - CNT_W'(1);
        end
        wait_d = (count_next >= CNT_W'(FIFO_DEPTH - 1));
    end

    // ------------------------------------------------------------------
    // Memory port: load the head one cycle after the FIFO is non-empty, hold
    // it until ack, then drop req for a cycle while the pop takes effect.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_region_d = mem_region_q;
        if (pop_ok) begin
            mem_req_d = 1'b0;
        end else if (!mem_req_q && !fifo_empty) begin
            mem_req_d    = 1'b1;
            mem_addr_d   = head.addr[ADDR_W-1:0];
            mem_data_d   = head.data;
            mem_region_d = head.region;
        end
    end

    // DIP capture is independent of the download flag and of the FSM.
    always_comb begin
        dip_d = dip_q;
        if (ioctl_wr && (ioctl_index == IDX_DIP)) begin
            for (int k = 0; k < int'(DIP_BYTES); k++) begin
                if (ioctl_addr == ADDR_W'(k)) begin
                    dip_d[8*k +: 8] = ioctl_dout;
                end
            end
        end
    end

    // Unmapped ROM bytes and pushes into a full FIFO are both lost bytes.
    assign addr_err_d = addr_err_q || (rom_strobe && (!rom_hit || fifo_full));

    // ------------------------------------------------------------------
    // Load sequencing FSM. core_reset/load_done are registered from the next
    // state so that they come out of reset as 1/0 and track state_q.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ioctl_download && (ioctl_index == IDX_ROM)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!ioctl_download) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ioctl_download && (ioctl_index == IDX_ROM)) begin
                    state_d = LOAD;
                end else if (fifo_empty && !mem_req_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        core_reset_d = (state_d != IDLE);
        load_done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_region_q <= '0;
            dip_q        <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_region_q <= mem_region_d;
            dip_q        <= dip_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
            addr_err_q   <= addr_err_d;
        end
    end

`ifdef IOCTL_ROUTER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if ((state_q == IDLE) && (state_d == LOAD)) begin
            sum_d = '0;
        end else if (pop_ok) begin
            sum_d = sum_q + 16'(mem_data_q);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign rom_sum = sum_q;
`endif

    assign ioctl_wait = wait_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_region = mem_region_q;
    assign dip_sw     = dip_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_ioctl_rom_router.sv
// tb/tb_ioctl_rom_router.sv - self-checking bench for ioctl_rom_router
module tb_ioctl_rom_router;

    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [7:0]    ioctl_index;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [2:0]    mem_region;
    logic          mem_ack;
    logic [63:0]   dip_sw;
    logic          core_reset;
    logic          load_done;
    logic          addr_err;
`ifdef IOCTL_ROUTER_CHECKSUM_EN
    logic [15:0]   rom_sum;
`endif

    always #5 clk_sys = ~clk_sys;

    ioctl_rom_router dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_region     (mem_region),
        .mem_ack        (mem_ack),
        .dip_sw         (dip_sw),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .addr_err       (addr_err)
`ifdef IOCTL_ROUTER_CHECKSUM_EN
        ,
        .rom_sum        (rom_sum)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [2:0]    region;
    } wr_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [63:0]   exp;
    } dip_vec_t;

    int  pass_cnt = 0;
    int  chk_cnt  = 0;
    wr_t exp_q[$];
    bit  drv_done;
    bit  err_exp;

    wr_t      rt[8];
    dip_vec_t dv[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Region map from the address rules: lowest region whose end is above addr.
    function automatic int ref_region(input logic [AW-1:0] a);
        if (a < 25'h0C000) return 0;
        if (a < 25'h14000) return 1;
        if (a < 25'h34000) return 2;
        if (a < 25'h80000) return 3;
        return -1;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] a;
        case ($urandom_range(0, 15))
            0:       a = 25'h0BFFF;
            1:       a = 25'h0C000;
            2:       a = 25'h13FFF;
            3:       a = 25'h14000;
            4:       a = 25'h33FFF;
            5:       a = 25'h34000;
            6:       a = 25'h7FFFF;
            7:       a = 25'h80000;
            default: a = AW'($urandom_range(0, 32'h9FFFF));
        endcase
        return a;
    endfunction

    task automatic wait_req(input string nm);
        int k = 0;
        while (!mem_req && k < 50) begin
            step();
            k++;
        end
        chk({nm, "_req"}, mem_req, 1);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!load_done && k < 200) begin
            step();
            k++;
        end
        chk({nm, "_done_seen"}, load_done, 1);
        chk({nm, "_done_core_rst"}, core_reset, 1);
        step();
        chk({nm, "_done_pulse"}, load_done, 0);
        chk({nm, "_core_rst_rel"}, core_reset, 0);
    endtask

    // One ROM load: the driver strobes n bytes honouring ioctl_wait and then
    // drops download; the responder acks each request after ack_dly cycles
    // (random 0..3 when negative) and checks it against the expected queue.
    task automatic run_load(input string nm, input int n, input int ack_dly, input bit rnd);
        int unsigned sum_exp;
        sum_exp  = 0;
        drv_done = 1'b0;
        exp_q.delete();
        fork
            begin : drv
                for (int i = 0; i < n; i++) begin
                    int            g, w, rg;
                    logic [AW-1:0] a;
                    logic [7:0]    d;
                    g = rnd ? int'($urandom_range(0, 2)) : 0;
                    repeat (g) step();
                    w = 0;
                    while (ioctl_wait && w < 100) begin
                        step();
                        w++;
                    end
                    if (w >= 100) chk({nm, "_wait_bound"}, ioctl_wait, 0);
                    a  = rnd ? pick_addr() : AW'(32'h1000 + i);
                    d  = 8'($urandom_range(0, 255));
                    rg = ref_region(a);
                    if (rg < 0) err_exp = 1'b1;
                    else begin
                        exp_q.push_back('{a, d, 3'(rg)});
                        sum_exp += d;
                    end
                    ioctl_download = 1'b1;
                    ioctl_index    = 8'd0;
                    ioctl_addr     = a;
                    ioctl_dout     = d;
                    ioctl_wr       = 1'b1;
                    step();
                    ioctl_wr = 1'b0;
                end
                ioctl_download = 1'b0;
                drv_done = 1'b1;
            end
            begin : rsp
                int guard = 0;
                while (!(drv_done && exp_q.size() == 0) && guard < 4000) begin
                    if (mem_req) begin
                        wr_t           e;
                        int            dl;
                        logic [AW-1:0] a0;
                        logic [7:0]    d0;
                        logic [2:0]    r0;
                        a0 = mem_addr;
                        d0 = mem_data;
                        r0 = mem_region;
                        chk({nm, "_core_rst_hold"}, core_reset, 1);
                        dl = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
                        repeat (dl) step();
                        chk({nm, "_req_stable"}, {mem_req, mem_addr, mem_data, mem_region},
                            {1'b1, a0, d0, r0});
                        if (exp_q.size() == 0) begin
                            chk({nm, "_spurious_write"}, 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk({nm, "_wr"}, {mem_addr, mem_data, mem_region},
                                {e.addr, e.data, e.region});
                        end
                        mem_ack = 1'b1;
                        step();
                        mem_ack = 1'b0;
                    end else begin
                        step();
                    end
                    guard++;
                end
                chk({nm, "_drain_bound"}, (guard < 4000), 1);
            end
        join
        chk({nm, "_addr_err"}, addr_err, err_exp);
        wait_done(nm);
`ifdef IOCTL_ROUTER_CHECKSUM_EN
        chk({nm, "_rom_sum"}, rom_sum, 16'(sum_exp));
`endif
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] acc;
        bit          saw;

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'd0;
        mem_ack        = 1'b0;
        err_exp        = 1'b0;
        repeat (2) step();

        // Reset state
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_region", mem_region, 0);
        chk("rst_dip", dip_sw, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_addr_err", addr_err, 0);
        reset = 1'b0;
        step();
        chk("idle_core_reset", core_reset, 0);

        // DIP capture table
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc[8*k +: 8] = 8'hA0 + 8'(k);
            dv[k] = '{AW'(k), 8'hA0 + 8'(k), acc};
        end
        dv[8] = '{AW'(8), 8'hFF, acc};
        dv[9] = '{AW'(200), 8'h5A, acc};
        ioctl_index = 8'd254;
        for (int i = 0; i < 10; i++) begin
            ioctl_addr = dv[i].addr;
            ioctl_dout = dv[i].data;
            ioctl_wr   = 1'b1;
            step();
            ioctl_wr = 1'b0;
            chk($sformatf("dip%0d", i), dip_sw, dv[i].exp);
        end
        step();
        chk("dip_final", dip_sw, 64'hA7A6A5A4A3A2A1A0);
        chk("dip_no_mem_req", mem_req, 0);

        // Region routing table, immediate ack
        rt[0] = '{25'h0BFFF, 8'h11, 3'd0};
        rt[1] = '{25'h0C000, 8'h22, 3'd1};
        rt[2] = '{25'h33FFF, 8'h33, 3'd2};
        rt[3] = '{25'h7FFFF, 8'h44, 3'd3};
        rt[4] = '{25'h00000, 8'h55, 3'd0};
        rt[5] = '{25'h13FFF, 8'h66, 3'd1};
        rt[6] = '{25'h14000, 8'h77, 3'd2};
        rt[7] = '{25'h34000, 8'h88, 3'd3};
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        for (int i = 0; i < 8; i++) begin
            ioctl_addr = rt[i].addr;
            ioctl_dout = rt[i].data;
            ioctl_wr   = 1'b1;
            step();
            ioctl_wr = 1'b0;
            wait_req($sformatf("route%0d", i));
            chk($sformatf("route%0d_addr", i), mem_addr, rt[i].addr);
            chk($sformatf("route%0d_data", i), mem_data, rt[i].data);
            chk($sformatf("route%0d_region", i), mem_region, rt[i].region);
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        ioctl_download = 1'b0;
        wait_done("route");
        chk("dip_kept_after_load", dip_sw, 64'hA7A6A5A4A3A2A1A0);
        chk("route_addr_err", addr_err, 0);

        // Back-pressure: ack held low, strobe every cycle
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        for (int i = 0; i < 4; i++) begin
            ioctl_addr = AW'(32'h200 + i);
            ioctl_dout = 8'hC0 + 8'(i);
            ioctl_wr   = 1'b1;
            step();
            chk($sformatf("bp_wait_push%0d", i), ioctl_wait, (i >= 2));
        end
        ioctl_wr = 1'b0;
        chk("bp_head", {mem_req, mem_addr}, {1'b1, 25'h200});
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("bp%0d", i));
            chk($sformatf("bp%0d_wr", i), {mem_addr, mem_data},
                {AW'(32'h200 + i), 8'hC0 + 8'(i)});
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        step();
        chk("bp_wait_fall", ioctl_wait, 0);
        chk("bp_no_extra_req", mem_req, 0);
        chk("bp_addr_err", addr_err, 0);
        ioctl_download = 1'b0;
        wait_done("bp");

        // Completion: 16 bytes, ack delayed 3 cycles, download falls early
        run_load("cmpl", 16, 3, 1'b0);

        // Randomised loads against the reference model
        run_load("rnd_a", 40, -1, 1'b1);
        run_load("rnd_b", 60, -1, 1'b1);

        // Unmapped address: dropped, sticky error until reset
        reset = 1'b1;
        step();
        reset   = 1'b0;
        err_exp = 1'b0;
        step();
        chk("err_clear_after_rst", addr_err, 0);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        ioctl_addr     = 25'h80000;
        ioctl_dout     = 8'h99;
        ioctl_wr       = 1'b1;
        step();
        ioctl_wr = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            step();
            if (mem_req) saw = 1'b1;
        end
        chk("err_no_mem_req", saw, 0);
        chk("err_set", addr_err, 1);
        ioctl_download = 1'b0;
        wait_done("err");
        repeat (3) step();
        chk("err_sticky", addr_err, 1);
        reset = 1'b1;
        step();
        chk("err_cleared_by_rst", addr_err, 0);
        reset = 1'b0;
        step();

        // Reset mid-load with a request pending
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        for (int i = 0; i < 2; i++) begin
            ioctl_addr = AW'(32'h300 + i);
            ioctl_dout = 8'h30 + 8'(i);
            ioctl_wr   = 1'b1;
            step();
        end
        ioctl_wr = 1'b0;
        wait_req("midrst");
        reset          = 1'b1;
        ioctl_download = 1'b0;
        step();
        chk("midrst_req_drop", mem_req, 0);
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_no_done", load_done, 0);
        reset = 1'b0;
        step();
        chk("midrst_core_rel", core_reset, 0);
        saw = 1'b0;
        repeat (6) begin
            step();
            if (mem_req || load_done) saw = 1'b1;
        end
        chk("midrst_fifo_flushed", saw, 0);
        chk("midrst_wait", ioctl_wait, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
